adc_axis_packer: RTL and testbench

- Stage directly downstream of the dual-channel serial ADC receiver.
- Captures each completed sample pair (channel 1 and channel 2) on a one-cycle strobe and packs it into one 32-bit word.
- Buffers the words in a small FIFO and presents them on an AXI4-Stream master, asserting TLAST every pkt_len samples so a DMA can frame the transfers.
- Reports overflow when the sink stalls for too long.

---
 rtl/adc_axis_packer_pkg.sv | 18 +
 rtl/adc_axis_packer_if.sv | 13 +
 rtl/adc_axis_packer_fifo.sv | 50 +++++
 rtl/adc_axis_packer.sv | 109 ++++++++++
 tb/tb_adc_axis_packer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_axis_packer_pkg.sv
// rtl/adc_axis_packer_pkg.sv - shared types, widths and packing helper for the ADC stream packer
package adc_axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } packer_state_t;

    localparam int AXIS_WIDTH = 32;
    localparam int CH_FIELD   = 16;

    // Channel 2 occupies the upper half so a little-endian DMA sees ch1 first.
    function automatic logic [AXIS_WIDTH-1:0] pack_pair(input logic [CH_FIELD-1:0] ch1,
                                                        input logic [CH_FIELD-1:0] ch2);
        return {ch2, ch1};
    endfunction

endpackage

// File: rtl/adc_axis_packer_if.sv
// rtl/adc_axis_packer_if.sv - AXI4-Stream bundle carrying packed ADC sample pairs
interface adc_axis_packer_if
    import adc_axis_pkg::*;
();
    logic [AXIS_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/adc_axis_packer_fifo.sv
// rtl/adc_axis_packer_fifo.sv - first-word-fall-through synchronous FIFO with occupancy output
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             wr_fire, rd_fire;

    // Full is taken from the current pointers, so a read in the same cycle never frees a slot early.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign level_o = wptr_q - rptr_q;
    assign wr_fire = wr_en_i && !full_o;
    assign rd_fire = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_fire) wptr_d = wptr_q + 1'b1;
        if (rd_fire) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (wr_fire) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/adc_axis_packer.sv
// rtl/adc_axis_packer.sv - packs ADC sample pairs into framed AXI4-Stream words with overflow reporting
module adc_axis_packer
    import adc_axis_pkg::*;
#(
    parameter int ADC_LENGTH = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int PACKET_LEN = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic [ADC_LENGTH-1:0]         adc_data1,
    input  logic [ADC_LENGTH-1:0]         adc_data2,
    input  logic [15:0]                   pkt_len,
    input  logic                          clr_status,
    adc_axis_packer_if.master             m_axis,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    packer_state_t state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   drop_q, drop_d;
    logic          ovf_q, ovf_d;

    logic [15:0]           cur_len, eff_len;
    logic                  run, full, empty, wr_en, drop, last;
    logic [AXIS_WIDTH:0]   wr_word, rd_word;

    // A new length is only picked up at a packet boundary so framing never tears mid-packet.
    assign cur_len = (pkt_len == 16'd0) ? 16'(PACKET_LEN) : pkt_len;
    assign eff_len = (cnt_q == 16'd0) ? cur_len : len_q;
    assign run     = (state_q == RUN);
    assign wr_en   = run && sample_valid && !full;
    assign drop    = run && sample_valid && full;
    assign last    = (cnt_q == eff_len - 16'd1);
    assign wr_word = {last, pack_pair(16'(adc_data1), 16'(adc_data2))};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN:  if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!run) begin
            cnt_d = 16'd0;
        end else if (wr_en) begin
            len_d = eff_len;
            cnt_d = last ? 16'd0 : cnt_q + 16'd1;
        end
    end

    // A drop in the same cycle as a clear wins, leaving a count of one.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = clr_status ? 16'd1 : ((drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1);
        end else if (clr_status) begin
            ovf_d  = 1'b0;
            drop_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            len_q   <= 16'd0;
            drop_q  <= 16'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (AXIS_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_word),
        .rd_en_i   (m_axis.tready),
        .rd_data_o (rd_word),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (fifo_level)
    );

    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = rd_word[AXIS_WIDTH-1:0];
    assign m_axis.tlast  = rd_word[AXIS_WIDTH];
    assign overflow      = ovf_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_adc_axis_packer.sv
// tb/tb_adc_axis_packer.sv - scoreboard bench for adc_axis_packer
module tb_adc_axis_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] adc_data1 = '0;
    logic [11:0] adc_data2 = '0;
    logic [15:0] pkt_len = 16'd4;
    logic        clr_status = 1'b0;
    logic        overflow;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;

    adc_axis_packer_if m_axis ();

    adc_axis_packer #(
        .ADC_LENGTH (12),
        .FIFO_DEPTH (16),
        .PACKET_LEN (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .adc_data1    (adc_data1),
        .adc_data2    (adc_data2),
        .pkt_len      (pkt_len),
        .clr_status   (clr_status),
        .m_axis       (m_axis),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] sb_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every presented word must be the oldest outstanding expectation, also while stalled.
    always @(negedge clk) begin
        if (rst && m_axis.tvalid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %0h expected none", {m_axis.tlast, m_axis.tdata});
            end else begin
                chk("axis_word", {31'd0, m_axis.tlast, m_axis.tdata}, {31'd0, sb_q[0]});
                if (m_axis.tready) void'(sb_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] exp_word(input logic [11:0] a, input logic [11:0] b);
        return {4'h0, b, 4'h0, a};
    endfunction

    task automatic strobe(input logic [11:0] a, input logic [11:0] b, input bit accept, input bit lst);
        adc_data1 = a;
        adc_data2 = b;
        sample_valid = 1'b1;
        if (accept) sb_q.push_back({lst, exp_word(a, b)});
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        m_axis.tready = 1'b1;
        idle(2);
        chk("rst_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, m_axis.tlast}, 64'd0);
        chk("rst_tdata", {32'd0, m_axis.tdata}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_drop_count", {48'd0, drop_count}, 64'd0);
        chk("rst_fifo_level", {59'd0, fifo_level}, 64'd0);

        // Four-sample packet, one word per strobe with a single cycle of latency.
        rst = 1'b1;
        enable = 1'b1;
        pkt_len = 16'd4;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            strobe(12'hABC, 12'h123, 1'b1, i == 3);
            chk("latency_tvalid", {63'd0, m_axis.tvalid}, 64'd1);
            chk("latency_tdata", {32'd0, m_axis.tdata}, 64'h0123_0ABC);
            idle(1);
        end

        // Default packet length: tlast on indices 255 and 511.
        pkt_len = 16'd0;
        for (int i = 0; i < 512; i++)
            strobe(12'(i), 12'(~i), 1'b1, (i % 256) == 255);
        idle(3);
        chk("default_len_drops", {48'd0, drop_count}, 64'd0);

        // Stall overflow: 16 stored, 4 dropped without advancing framing.
        pkt_len = 16'd5;
        m_axis.tready = 1'b0;
        for (int i = 0; i < 20; i++)
            strobe(12'(100 + i), 12'(200 + i), i < 16, (i < 16) && ((i % 5) == 4));
        chk("ovf_level", {59'd0, fifo_level}, 64'd16);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        chk("ovf_drop_count", {48'd0, drop_count}, 64'd4);
        m_axis.tready = 1'b1;
        idle(20);
        chk("ovf_drained", {59'd0, fifo_level}, 64'd0);
        for (int i = 0; i < 4; i++)
            strobe(12'(300 + i), 12'(400 + i), 1'b1, i == 3);
        clr_status = 1'b1;
        idle(1);
        clr_status = 1'b0;
        chk("clr_overflow", {63'd0, overflow}, 64'd0);
        chk("clr_drop_count", {48'd0, drop_count}, 64'd0);

        // Toggling tready while strobing back to back.
        pkt_len = 16'd3;
        m_axis.tready = 1'b0;
        fork
            begin
                repeat (40) begin
                    m_axis.tready = ~m_axis.tready;
                    @(posedge clk); #1;
                end
            end
            begin
                for (int i = 0; i < 12; i++)
                    strobe(12'(12'h500 + i), 12'(12'h600 + i), 1'b1, (i % 3) == 2);
            end
        join
        m_axis.tready = 1'b1;
        idle(20);
        chk("toggle_no_drop", {48'd0, drop_count}, 64'd0);

        // Disable mid-packet, then a fresh packet after re-enable.
        pkt_len = 16'd4;
        strobe(12'h011, 12'h022, 1'b1, 1'b0);
        strobe(12'h033, 12'h044, 1'b1, 1'b0);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++)
            strobe(12'(12'h700 + i), 12'(12'h7F0 + i), 1'b1, i == 3);
        idle(8);

        // Drop coinciding with clr_status leaves a count of one.
        pkt_len = 16'd5;
        m_axis.tready = 1'b0;
        for (int i = 0; i < 18; i++)
            strobe(12'(12'h800 + i), 12'(12'h900 + i), i < 16, (i < 16) && ((i % 5) == 4));
        chk("pre_clr_drop_count", {48'd0, drop_count}, 64'd2);
        clr_status = 1'b1;
        strobe(12'hFFF, 12'hFFF, 1'b0, 1'b0);
        clr_status = 1'b0;
        chk("clr_drop_overflow", {63'd0, overflow}, 64'd1);
        chk("clr_drop_count", {48'd0, drop_count}, 64'd1);

        // Drain to 8 buffered words, then reset asynchronously mid-cycle.
        m_axis.tready = 1'b1;
        idle(8);
        m_axis.tready = 1'b0;
        idle(1);
        chk("pre_rst_level", {59'd0, fifo_level}, 64'd8);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
        chk("async_rst_level", {59'd0, fifo_level}, 64'd0);
        chk("async_rst_overflow", {63'd0, overflow}, 64'd0);
        chk("async_rst_drop_count", {48'd0, drop_count}, 64'd0);
        sb_q.delete();
        idle(2);
        rst = 1'b1;
        pkt_len = 16'd2;
        m_axis.tready = 1'b1;
        idle(1);
        strobe(12'h0A1, 12'h0B1, 1'b1, 1'b0);
        strobe(12'h0A2, 12'h0B2, 1'b1, 1'b1);
        idle(5);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
